// File: rtl/rst_sequencer.sv
// Central SoC reset sequencer: arbitrates POR, pin, software and fault requests,
// holds every domain in reset, then releases domains one at a time in index order.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ASSERT  | all domains held in reset; cnt times the hold window
// RELEASE | domains released one per STAGE_GAP cycles, idx = last released
// RUN     | every domain released, waiting for the next request
module rst_sequencer #(
    parameter int DOMAINS     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int DEBOUNCE    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rst_ib,
    input  logic               sw_req,
    input  logic               fault_req,
    output logic [DOMAINS-1:0] rst_ob,
    output logic               busy,
    output logic [1:0]         cause,
    output logic               cause_upd
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;
    localparam int DEB_W   = $clog2(DEBOUNCE + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DOMAINS - 2);
    localparam logic [DEB_W-1:0] DEB_SAT   = DEB_W'(DEBOUNCE);

    localparam logic [1:0] CAUSE_POR   = 2'd0;
    localparam logic [1:0] CAUSE_PIN   = 2'd1;
    localparam logic [1:0] CAUSE_SW    = 2'd2;
    localparam logic [1:0] CAUSE_FAULT = 2'd3;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [1:0]       pin_sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             pin_req;
    logic             req_any;
    logic [1:0]       req_cause;

    // Pin path: two-flop synchroniser, then a saturating low-sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_sync <= 2'b11;
            deb_cnt  <= '0;
        end else begin
            pin_sync <= {pin_sync[0], rst_ib};
            if (pin_sync[1]) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_SAT) begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign pin_req = (deb_cnt == DEB_SAT);
    assign req_any = fault_req | pin_req | sw_req;

    always_comb begin
        req_cause = CAUSE_POR;
        if (fault_req) begin
            req_cause = CAUSE_FAULT;
        end else if (pin_req) begin
            req_cause = CAUSE_PIN;
        end else if (sw_req) begin
            req_cause = CAUSE_SW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            idx       <= '0;
            rst_ob    <= '0;
            busy      <= 1'b1;
            cause     <= CAUSE_POR;
            cause_upd <= 1'b0;
        end else begin
            cause_upd <= 1'b0;
            // Any request, from any state, (re)starts the hold window.
            if (req_any) begin
                state     <= ST_ASSERT;
                cnt       <= '0;
                idx       <= '0;
                rst_ob    <= '0;
                busy      <= 1'b1;
                cause     <= req_cause;
                cause_upd <= 1'b1;
            end else begin
                case (state)
                    ST_ASSERT: begin
                        rst_ob <= '0;
                        busy   <= 1'b1;
                        if (cnt == HOLD_LAST) begin
                            cnt    <= '0;
                            idx    <= '0;
                            rst_ob <= DOMAINS'(1);
                            if (DOMAINS == 1) begin
                                state <= ST_RUN;
                                busy  <= 1'b0;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt == GAP_LAST) begin
                            cnt    <= '0;
                            // Released bits are contiguous from bit 0, so shifting in a one
                            // releases exactly domain idx+1.
                            rst_ob <= (rst_ob << 1) | DOMAINS'(1);
                            idx    <= idx + IDX_W'(1);
                            if (idx == IDX_LAST) begin
                                state <= ST_RUN;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        rst_ob <= '1;
                        busy   <= 1'b0;
                    end
                    default: begin
                        state  <= ST_ASSERT;
                        cnt    <= '0;
                        idx    <= '0;
                        rst_ob <= '0;
                        busy   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Central reset sequencer for the SoC.
- Arbitrates reset requests from power-on, the external reset pin, software (register write) and SoC fault.
- On any accepted request it asserts all domain resets, holds them for a fixed time, then releases the domains one at a time in index order.
- Sits between the pin/fault sources and per-domain reset nets; the reset controller's register block reads cause/busy and drives sw_req.

Parameters:
- DOMAINS, 4: number of reset domains; domain 0 is released first.
- HOLD_CYCLES, 16: cycles all domains stay asserted (minimum 1).
- STAGE_GAP, 4: cycles between consecutive domain releases (minimum 1).
- DEBOUNCE, 8: consecutive low samples of the synchronised pin required to accept a pin request (minimum 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high power-on reset.
- rst_ib  input  1  external reset pin, active-low, asynchronous to clk.
- sw_req  input  1  software reset request; single-cycle pulse, level also accepted.
- fault_req  input  1  SoC fault reset request, level or pulse.
- rst_ob  output  DOMAINS  per-domain reset, active-low (0 = domain held in reset).
- busy  output  1  high while the sequence is in progress.
- cause  output  2  last accepted cause: 0 POR, 1 PIN, 2 SW, 3 FAULT.
- cause_upd  output  1  one-cycle pulse when cause is loaded.

Behaviour:
- Async reset (rst=1) forces:
  - rst_ob = all 0, busy = 1, cause = 0, cause_upd = 0
  - state = ASSERT, counters = 0, sync flops = 1, debounce counter = 0
- All outputs are registered.
- Pin path:
  - rst_ib passes through a 2-flop synchroniser.
  - The debounce counter increments while the synchronised value is 0 and clears when it is 1.
  - pin_req is asserted while the counter has reached DEBOUNCE; the counter saturates there.
- req_any = fault_req | pin_req | sw_req.
- Cause priority for simultaneous requests: FAULT > PIN > SW.
- FSM states: ASSERT, RELEASE, RUN.
  - ASSERT:
    - rst_ob = all 0; cnt counts 0..HOLD_CYCLES-1.
    - req_any restarts cnt at 0.
    - At cnt == HOLD_CYCLES-1 with no request: go to RELEASE, idx = 0, set rst_ob[0] = 1 on the same edge.
  - RELEASE:
    - cnt counts 0..STAGE_GAP-1.
    - At terminal count, set rst_ob[idx+1] = 1 and increment idx.
    - When the last domain (DOMAINS-1) is released: go to RUN, busy = 0 on the same edge.
    - req_any forces ASSERT: rst_ob = all 0, cnt = 0, busy = 1.
  - RUN:
    - rst_ob = all 1, busy = 0.
    - req_any goes to ASSERT at the next edge; rst_ob = all 0 from that edge.
- Request-to-reset latency:
  - sw_req / fault_req: 1 cycle.
  - pin: 2 sync cycles plus DEBOUNCE cycles, then 1 cycle.
- Release timing: domain k is released exactly HOLD_CYCLES + k*STAGE_GAP cycles after the ASSERT entry edge, or after rst deassertion.
- Cause update:
  - cause and cause_upd are loaded on each edge that enters ASSERT from RELEASE or RUN, and on each restart inside ASSERT.
  - During ASSERT a new request overwrites cause.
  - POR cause is held until the first request.
- A level request held high keeps the block in ASSERT indefinitely; release begins HOLD_CYCLES after the request drops.
- A pin held low keeps pin_req high, so the block stays in ASSERT.
- Mid-sequence rst assertion returns everything to reset values immediately and asynchronously.
- Released domains never re-assert except via ASSERT; rst_ob bits never release out of index order.

Test Plan:
- POR: rst high 3 cycles, then low; defaults (DOMAINS=4, HOLD=16, GAP=4) -> rst_ob = 0000 for 16 cycles, then 0001 @16, 0011 @20, 0111 @24, 1111 @28; busy falls @28; cause = 0, no cause_upd.
- SW reset in RUN: sw_req pulse at cycle T -> rst_ob = 0000 and busy = 1 from T+1; cause = 2 with cause_upd pulse at T+1; full release at T+1+28.
- Pin debounce: rst_ib low for 5 cycles then high -> no reset. rst_ib low for 12 cycles -> ASSERT entered 2+8+1 cycles after the falling edge; cause = 1.
- Simultaneous sw_req and fault_req in RUN -> cause = 3, single cause_upd pulse, normal sequence.
- Request during RELEASE: fault_req pulse when rst_ob = 0011 -> next cycle rst_ob = 0000, busy = 1; domain 0 re-released 16 cycles later.
- Async rst asserted mid-RELEASE (rst_ob = 0111) -> rst_ob = 0000 without a clock edge, cause = 0; the sequence restarts on deassertion.
